// File: rtl/regfile_writeback.sv
// Writeback stage driving the register file write port.
// Arbitrates between ALU results and load responses, aligns and extends
// load data, and presents at most one registered write per cycle. The
// register file commits the presented write on the following negedge.
module regfile_writeback #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [2:0]            ld_op,
  input  logic [1:0]            ld_off,
  input  logic [ADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0] ld_word,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [3:0]            wr_be_n,
  output logic                  ld_err
);

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LWL = 3'b010,
    OP_LW  = 3'b011,
    OP_LBU = 3'b100,
    OP_LHU = 3'b101,
    OP_LWR = 3'b110,
    OP_RSV = 3'b111
  } ld_op_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]            cnt;
  logic                  starve;
  logic                  alu_acc;
  logic                  ld_acc;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [3:0]            ld_be_n;
  logic                  ld_bad;

  // The ALU only wins once it has been blocked STARVE_LIMIT cycles in a row
  assign starve    = (cnt == LIMIT);
  assign alu_ready = !ld_valid || starve;
  assign ld_ready  = !(alu_valid && starve);
  assign alu_acc   = alu_valid && alu_ready;
  assign ld_acc    = ld_valid && ld_ready;

  // Byte and halfword selected by the low address bits of the load
  assign sel_byte = 8'(ld_word >> {ld_off, 3'b000});
  assign sel_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];

  // Align/extend the load word and flag misaligned or reserved requests
  always_comb begin
    ld_data = '0;
    ld_be_n = 4'b0000;
    ld_bad  = 1'b0;
    case (ld_op_e'(ld_op))
      OP_LB:  ld_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU: ld_data = {24'h000000, sel_byte};
      OP_LH: begin
        ld_data = {{16{sel_half[15]}}, sel_half};
        ld_bad  = ld_off[0];
      end
      OP_LHU: begin
        ld_data = {16'h0000, sel_half};
        ld_bad  = ld_off[0];
      end
      OP_LW: begin
        ld_data = ld_word;
        ld_bad  = (ld_off != 2'd0);
      end
      OP_LWL: begin
        ld_data = ld_word << {~ld_off, 3'b000};
        case (ld_off)
          2'd0:    ld_be_n = 4'b0111;
          2'd1:    ld_be_n = 4'b0011;
          2'd2:    ld_be_n = 4'b0001;
          default: ld_be_n = 4'b0000;
        endcase
      end
      OP_LWR: begin
        ld_data = ld_word >> {ld_off, 3'b000};
        case (ld_off)
          2'd0:    ld_be_n = 4'b0000;
          2'd1:    ld_be_n = 4'b1000;
          2'd2:    ld_be_n = 4'b1100;
          default: ld_be_n = 4'b1110;
        endcase
      end
      default: ld_bad = 1'b1;
    endcase
  end

  // Count consecutive cycles the ALU is held off, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (!alu_valid || alu_acc) begin
      cnt <= 4'd0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Register the accepted write for one cycle; writes to r0 and dropped loads stay idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_be_n  <= 4'b1111;
      ld_err   <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      wr_be_n  <= 4'b1111;
      ld_err   <= ld_acc && ld_bad;
      if (alu_acc && (alu_rd != '0)) begin
        wr_valid <= 1'b1;
        wr_addr  <= alu_rd;
        wr_data  <= alu_data;
        wr_be_n  <= 4'b0000;
      end else if (ld_acc && !ld_bad && (ld_rd != '0)) begin
        wr_valid <= 1'b1;
        wr_addr  <= ld_rd;
        wr_data  <= ld_data;
        wr_be_n  <= ld_be_n;
      end
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed testbench for regfile_writeback with a byte-enabled register
// file model and a scoreboard of expected registered writes.
module tb_regfile_writeback;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  ld_op;
  logic [1:0]  ld_off;
  logic [4:0]  ld_rd;
  logic [31:0] ld_word;
  logic        wr_valid;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be_n;
  logic        ld_err;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] rf[32];
  int          checks;
  int          errors;

  regfile_writeback #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5),
    .STARVE_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_valid(alu_valid),
    .alu_ready(alu_ready),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .ld_valid(ld_valid),
    .ld_ready(ld_ready),
    .ld_op(ld_op),
    .ld_off(ld_off),
    .ld_rd(ld_rd),
    .ld_word(ld_word),
    .wr_valid(wr_valid),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_be_n(wr_be_n),
    .ld_err(ld_err)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file sink: commits presented writes at the negedge, per byte
  always @(negedge clk) begin
    if (wr_valid) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_be_n[b]) rf[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic v, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] be, input logic err);
    exp_t e;
    e.v = v; e.a = a; e.d = d; e.be = be; e.err = err;
    sb.push_back(e);
  endtask

  task automatic push_idle(input logic err);
    push_exp(1'b0, 5'd0, 32'h0, 4'hF, err);
  endtask

  // Drive one cycle of inputs (at a negedge) and check the combinational readies
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                               input logic lv, input logic [2:0] op, input logic [1:0] off,
                               input logic [4:0] lrd, input logic [31:0] w,
                               input logic exp_ar, input logic exp_lr, input string tag);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_op = op; ld_off = off; ld_rd = lrd; ld_word = w;
    #1;
    check_eq({tag, ".alu_ready"}, 32'(alu_ready), 32'(exp_ar));
    check_eq({tag, ".ld_ready"}, 32'(ld_ready), 32'(exp_lr));
  endtask

  // Wait past the next posedge and compare the presented write with the scoreboard
  task automatic checkOutput(input string tag);
    exp_t e;
    @(negedge clk);
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("[TB] FAIL %s scoreboard observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_eq({tag, ".wr_valid"}, 32'(wr_valid), 32'(e.v));
      check_eq({tag, ".wr_addr"}, 32'(wr_addr), 32'(e.a));
      check_eq({tag, ".wr_data"}, wr_data, e.d);
      check_eq({tag, ".wr_be_n"}, 32'(wr_be_n), 32'(e.be));
      check_eq({tag, ".ld_err"}, 32'(ld_err), 32'(e.err));
    end
  endtask

  task automatic idle_cycle(input logic exp_err, input string tag);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b1, tag);
    push_idle(exp_err);
    checkOutput(tag);
  endtask

  // Directed sequence
  initial begin
    logic [31:0] ld_w;
    logic [31:0] alu_d;
    logic        alu_turn;
    checks = 0;
    errors = 0;
    for (int r = 0; r < 32; r++) rf[r] = 32'h0;
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_op = '0; ld_off = '0; ld_rd = '0; ld_word = '0;

    repeat (2) @(negedge clk);
    check_eq("reset.wr_valid", 32'(wr_valid), 32'd0);
    check_eq("reset.wr_be_n", 32'(wr_be_n), 32'hF);
    check_eq("reset.ld_err", 32'(ld_err), 32'd0);
    rst_n = 1'b1;

    idle_cycle(1'b0, "idle0");

    // Byte loads from 80FF_7F01
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b000, 2'd1, 5'd1, 32'h80FF_7F01, 1'b0, 1'b1, "lb_k1");
    push_exp(1'b1, 5'd1, 32'h0000_007F, 4'h0, 1'b0);
    checkOutput("lb_k1");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b000, 2'd3, 5'd2, 32'h80FF_7F01, 1'b0, 1'b1, "lb_k3");
    push_exp(1'b1, 5'd2, 32'hFFFF_FF80, 4'h0, 1'b0);
    checkOutput("lb_k3");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b100, 2'd3, 5'd3, 32'h80FF_7F01, 1'b0, 1'b1, "lbu_k3");
    push_exp(1'b1, 5'd3, 32'h0000_0080, 4'h0, 1'b0);
    checkOutput("lbu_k3");

    // Halfword loads from AABB_CCDD
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b001, 2'd2, 5'd5, 32'hAABB_CCDD, 1'b0, 1'b1, "lh_k2");
    push_exp(1'b1, 5'd5, 32'hFFFF_AABB, 4'h0, 1'b0);
    checkOutput("lh_k2");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b101, 2'd0, 5'd6, 32'hAABB_CCDD, 1'b0, 1'b1, "lhu_k0");
    push_exp(1'b1, 5'd6, 32'h0000_CCDD, 4'h0, 1'b0);
    checkOutput("lhu_k0");

    // LWL then LWR merge into register 4
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b010, 2'd1, 5'd4, 32'hAABB_CCDD, 1'b0, 1'b1, "lwl_k1");
    push_exp(1'b1, 5'd4, 32'hCCDD_0000, 4'b0011, 1'b0);
    checkOutput("lwl_k1");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b110, 2'd2, 5'd4, 32'hAABB_CCDD, 1'b0, 1'b1, "lwr_k2");
    push_exp(1'b1, 5'd4, 32'h0000_AABB, 4'b1100, 1'b0);
    checkOutput("lwr_k2");
    #1;
    check_eq("rf4_merge", rf[4], 32'hCCDD_AABB);

    // Misaligned and reserved loads: accepted, dropped, one-cycle error
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b001, 2'd1, 5'd8, 32'h1111_2222, 1'b0, 1'b1, "lh_mis");
    push_idle(1'b1);
    checkOutput("lh_mis");
    idle_cycle(1'b0, "lh_mis_after");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b111, 2'd0, 5'd8, 32'h1111_2222, 1'b0, 1'b1, "rsv_op");
    push_idle(1'b1);
    checkOutput("rsv_op");
    idle_cycle(1'b0, "rsv_after");
    check_eq("rf8_untouched", rf[8], 32'h0);

    // ALU writes: r0 suppressed, r7 committed
    applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b1, "alu_r0");
    push_idle(1'b0);
    checkOutput("alu_r0");
    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, 3'd0, 2'd0, 5'd0, 32'h0, 1'b1, 1'b1, "alu_r7");
    push_exp(1'b1, 5'd7, 32'h1234_5678, 4'h0, 1'b0);
    checkOutput("alu_r7");
    #1;
    check_eq("rf7", rf[7], 32'h1234_5678);
    check_eq("rf0", rf[0], 32'h0);
    idle_cycle(1'b0, "pre_starve");

    // Both sources valid continuously: three loads then one ALU write, repeating
    ld_w  = 32'h0000_1000;
    alu_d = 32'hA000_0000;
    for (int j = 0; j < 12; j++) begin
      alu_turn = ((j % 4) == 3);
      applyStimulus(1'b1, 5'd11, alu_d, 1'b1, 3'b011, 2'd0, 5'd10, ld_w,
                    alu_turn, !alu_turn, $sformatf("starve%0d", j));
      if (alu_turn) push_exp(1'b1, 5'd11, alu_d, 4'h0, 1'b0);
      else          push_exp(1'b1, 5'd10, ld_w, 4'h0, 1'b0);
      checkOutput($sformatf("starve%0d", j));
      if (alu_turn) alu_d = alu_d + 32'd1;
      else          ld_w = ld_w + 32'd1;
    end
    idle_cycle(1'b0, "post_starve");

    // Asynchronous reset while a write is being presented
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 3'b011, 2'd0, 5'd9, 32'h5555_AAAA, 1'b0, 1'b1, "mid_rst");
    push_exp(1'b1, 5'd9, 32'h5555_AAAA, 4'h0, 1'b0);
    @(posedge clk);
    #1;
    check_eq("mid_rst.pre_valid", 32'(wr_valid), 32'd1);
    void'(sb.pop_front());
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst.wr_valid", 32'(wr_valid), 32'd0);
    check_eq("mid_rst.wr_addr", 32'(wr_addr), 32'd0);
    check_eq("mid_rst.wr_data", wr_data, 32'h0);
    check_eq("mid_rst.wr_be_n", 32'(wr_be_n), 32'hF);
    check_eq("mid_rst.ld_ready", 32'(ld_ready), 32'd1);
    check_eq("mid_rst.alu_ready", 32'(alu_ready), 32'd0);
    @(negedge clk);
    ld_valid = 1'b0;
    rst_n = 1'b1;
    idle_cycle(1'b0, "after_rst");
    check_eq("rf9_not_written", rf[9], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback stage that drives the 32x32 register file's write port (`Rd_addr`, `Rd_in`, active-low `Rd_Byte_w_en`). Arbitrates between ALU results and load responses with a valid/ready handshake. Performs load alignment and sign or zero extension, including byte-merging LWL/LWR through the active-low byte enables. Emits at most one registered write per cycle; the register file commits it on the following negative clock edge.

## Interface
- `DATA_WIDTH`, 32, register and memory word width (only 32 supported)
- `ADDR_WIDTH`, 5, register address width
- `STARVE_LIMIT`, 3, consecutive blocked ALU cycles before the ALU is granted priority (1..15)
- `clk`  in  1  clock; all state updates on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result offered
- `alu_ready`  out  1  ALU result accepted this cycle when high with `alu_valid`
- `alu_rd`  in  5  destination register
- `alu_data`  in  32  result word
- `ld_valid`  in  1  load response offered
- `ld_ready`  out  1  load response accepted when high with `ld_valid`
- `ld_op`  in  3  000 LB, 001 LH, 010 LWL, 011 LW, 100 LBU, 101 LHU, 110 LWR, 111 reserved
- `ld_off`  in  2  byte address bits [1:0] of the load
- `ld_rd`  in  5  destination register
- `ld_word`  in  32  aligned memory word (little-endian; byte k = bits [8k+7:8k])
- `wr_valid`  out  1  a write is presented this cycle
- `wr_addr`  out  5  to `Rd_addr`
- `wr_data`  out  32  to `Rd_in`
- `wr_be_n`  out  4  to `Rd_Byte_w_en`; bit i = 0 writes byte i
- `ld_err`  out  1  one-cycle pulse: misaligned or reserved load dropped

## Operation
- Arbitration: `starve = (cnt == STARVE_LIMIT)`.
  - `alu_ready = !ld_valid || starve`
  - `ld_ready = !(alu_valid && starve)`
  - Exactly one source is accepted per cycle; the load wins by default.
- Starve counter `cnt`:
  - Increments, saturating, on each cycle with `alu_valid && !alu_ready`.
  - Clears on ALU accept or whenever `alu_valid` is 0.
- ALU accept: `wr_data = alu_data`, `wr_be_n = 4'b0000`.
- Load accept, with k = `ld_off`:
  - LB/LBU: byte k, sign- or zero-extended; `be_n = 0000`.
  - LH/LHU: halfword k[1], extended; `be_n = 0000`; k[0]=1 is an error.
  - LW: whole word; `be_n = 0000`; k≠0 is an error.
  - LWL: `data = ld_word << 8*(3-k)`; `be_n` = 0111, 0011, 0001, 0000 for k = 0..3.
  - LWR: `data = ld_word >> 8*k`; `be_n` = 0000, 1000, 1100, 1110 for k = 0..3.
  - Error (misaligned or op 111): the handshake completes, no write is issued, and `ld_err` pulses the next cycle.
- Writes to destination 0 are presented idle (`wr_valid = 0`, `be_n = 1111`).
- Idle output: `wr_valid = 0`, `wr_addr = 0`, `wr_data = 0`, `wr_be_n = 4'b1111`.

## Timing
- Reset (asynchronous assert, mid-operation included):
  - All outputs go to idle immediately; `ld_err = 0`, `cnt = 0`.
  - Ready outputs are combinational and track the inputs.
- Latency: an accept at posedge N presents the write from N to N+1. The register file commits it at the negedge inside that cycle.
- Output registers are single-cycle. They return to idle at N+1 unless another accept occurs; back-to-back writes run at one per cycle.
- Ready signals depend only on the valids and `cnt`; the valids must not depend on the readies.
- A source holding valid without being accepted keeps its payload stable.
- Simultaneous valids for STARVE_LIMIT cycles:
  - The load is accepted on each of those cycles.
  - On cycle STARVE_LIMIT+1 the ALU is accepted and `ld_ready = 0`.
  - `cnt` then clears.

## Test plan
- Reset released, no valids → `wr_be_n = F`, `wr_valid = 0`, both readies high; assert `rst_n = 0` while a write is presented → outputs idle within the same cycle.
- LB with `ld_word = 32'h80FF_7F01`:
  - k=1 → `wr_data = 32'h0000_007F`
  - k=3 → `32'hFFFF_FF80`
  - LBU k=3 → `32'h0000_0080`
  - `be_n = 0` in all cases.
- LWL k=1 with `ld_word = 32'hAABB_CCDD` → `wr_data = 32'hCCDD_0000`, `wr_be_n = 4'b0011`; LWR k=2 → `wr_data = 32'h0000_AABB`, `wr_be_n = 4'b1100`.
- LH k=1 and op 111 → no write (`wr_valid = 0`), `ld_err` high for exactly one cycle each, `ld_ready` high at accept.
- Continuous `ld_valid` and `alu_valid` (STARVE_LIMIT=3) → 3 load writes, then 1 ALU write, then loads resume; pattern repeats every 4 cycles.
- ALU write with `alu_rd = 0` → `wr_valid = 0`, `be_n = F`; `alu_rd = 7`, `alu_data = 32'h1234_5678` → register 7 reads `32'h1234_5678` after the following negedge.
